fpu_sequencer: RTL and testbench
================================

# fpu_sequencer

Multi-cycle sequencer for the floating-point unit in the RISC-V CPU. Sits between the decode stage and the FPU datapath. When decode flags a float instruction, the block classifies it from funct_7/funct_3 and starts the FPU unit. It stalls the front end for the operation's latency, then holds a write-back request until the register file accepts it. Flush and illegal-encoding handling are included.

## Interface
Parameters:
- ADD_LAT, 2, cycles for FADD/FSUB
- MUL_LAT, 3, cycles for FMUL
- DIV_LAT, 12, cycles for FDIV
- SQRT_LAT, 16, cycles for FSQRT
- CNT_W, 5, latency counter width; must hold max(LAT)-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode holds a float instruction (float_ctrl & valid)
- funct_7  in  7  instruction funct_7
- funct_3  in  3  instruction funct_3
- rd  in  5  destination register index
- wb_ready  in  1  register-file write port accepts this cycle
- flush  in  1  pipeline flush (branch/jump redirect)
- stall  out  1  freeze PC and decode (combinational)
- illegal  out  1  unsupported float encoding (combinational)
- fpu_start  out  1  one-cycle start pulse to the FPU unit (registered)
- fpu_op  out  4  latched operation code (registered)
- fpu_abort  out  1  one-cycle pulse when a flush kills an operation
- wb_valid  out  1  result ready for write-back
- wb_rd  out  5  latched destination
- wb_int  out  1  1 = write the integer register file, 0 = write the float register file
- busy  out  1  state != IDLE

## Operation
- fpu_op decode (funct_7, funct_3):
  - 0000000 → ADD=0; 0000100 → SUB=1; 0001000 → MUL=2; 0001100 → DIV=3; 0101100 → SQRT=4
  - 0010000 with f3 0–2 → SGNJ=5; 0010100 with f3 0–1 → MINMAX=6; 1010000 with f3 0–2 → CMP=7
  - 1100000 → CVT_W_S=8; 1101000 → CVT_S_W=9; 1110000 with f3 0 → MV_X_W=10; 1111000 → MV_W_X=11
  - anything else is illegal
- Latency LAT: ADD/SUB use ADD_LAT, MUL uses MUL_LAT, DIV uses DIV_LAT, SQRT uses SQRT_LAT; all other ops use 1.
- wb_int=1 for CMP, CVT_W_S, MV_X_W.
- States: IDLE, BUSY, WB.
  - IDLE: on issue_valid & legal & ~flush, latch fpu_op/rd/wb_int, load cnt=LAT-1, go to BUSY.
    - issue_valid & illegal: illegal=1, stall=0, no state change.
  - BUSY: fpu_start=1 in the first BUSY cycle only. If cnt==0, go to WB; else cnt decrements.
  - WB: wb_valid=1. On wb_ready, go to IDLE.
  - flush in BUSY or WB: go to IDLE at the next edge, pulse fpu_abort, never assert wb_valid again for that op. flush wins over a simultaneous wb_ready.
- stall = (IDLE & issue_valid & legal & ~flush) | BUSY | (WB & ~wb_ready).
- Reset (async, rst_n=0) sets: state=IDLE, cnt=0, fpu_start=0, fpu_op=0, fpu_abort=0, wb_valid=0, wb_rd=0, wb_int=0, busy=0. Reset mid-operation drops the op silently.

## Timing
- Issue cycle C0 (IDLE, stall=1).
- BUSY occupies C1..C_LAT; fpu_start is high in C1.
- wb_valid rises in C_LAT+1 and holds (with wb_rd/wb_int stable) until wb_ready.
- stall is high C0..C_LAT. stall is low in the handshake cycle, so decode advances on the same edge the sequencer returns to IDLE. The held instruction is never re-issued.
- Single-cycle ops (LAT=1): BUSY is 1 cycle; wb_valid appears in C2.
- Back-to-back float instructions: the next issue can be accepted in the cycle after the WB handshake.
- issue_valid is ignored outside IDLE.

## Test plan
- FADD (funct_7=0000000, rd=5), wb_ready=1:
  - fpu_start high in C1 only, fpu_op=0
  - wb_valid high in C3 with wb_rd=5, wb_int=0
  - stall high C0..C2
- FDIV with wb_ready held low 3 extra cycles: wb_valid from C13 held 4 cycles; stall high through C15; IDLE after C16.
- FEQ (1010000, f3=2, rd=9): LAT=1, wb_valid in C2, wb_int=1, fpu_op=7.
- Illegal (funct_7=1110000, f3=1): illegal=1, stall=0, fpu_start never asserted, state stays IDLE.
- FSQRT with flush at C8: fpu_abort pulse at C9, busy=0 at C9, wb_valid never rises; the next FMUL issues cleanly.
- rst_n low at C5 of an FMUL: all outputs 0 immediately (async); after release, a FSUB completes with wb_valid in C3.

Source files
------------

// File: rtl/fpu_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_sequencer
//
// Multi-cycle sequencer between the decode stage and the FPU datapath.
// It classifies a float instruction from funct_7/funct_3 and starts the FPU.
// It then stalls the front end for the latency of the operation. After that
// it holds a write-back request until the register file accepts it.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   issue_valid  decode presents a float instruction
//   funct_7      instruction funct_7 field
//   funct_3      instruction funct_3 field
//   rd           destination register index
//   wb_ready     register-file write port accepts this cycle
//   flush        pipeline redirect; kills any in-flight operation
//   stall        freeze PC/decode (combinational)
//   illegal      unsupported float encoding seen in IDLE (combinational)
//   fpu_start    one-cycle start pulse to the FPU (registered)
//   fpu_op       latched operation code (registered)
//   fpu_abort    one-cycle pulse after a flush kills an operation
//   wb_valid     result ready for write-back
//   wb_rd        latched destination register
//   wb_int       1 = integer register file, 0 = float register file
//   busy         sequencer not idle
// ---------------------------------------------------------------------------
module fpu_sequencer #(
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 12,
    parameter int SQRT_LAT = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [6:0] funct_7,
    input  logic [2:0] funct_3,
    input  logic [4:0] rd,
    input  logic       wb_ready,
    input  logic       flush,
    output logic       stall,
    output logic       illegal,
    output logic       fpu_start,
    output logic [3:0] fpu_op,
    output logic       fpu_abort,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_int,
    output logic       busy
);

    // Operation codes driven on fpu_op
    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_SQRT    = 4'd4;
    localparam logic [3:0] OP_SGNJ    = 4'd5;
    localparam logic [3:0] OP_MINMAX  = 4'd6;
    localparam logic [3:0] OP_CMP     = 4'd7;
    localparam logic [3:0] OP_CVT_W_S = 4'd8;
    localparam logic [3:0] OP_CVT_S_W = 4'd9;
    localparam logic [3:0] OP_MV_X_W  = 4'd10;
    localparam logic [3:0] OP_MV_W_X  = 4'd11;

    // Counter preload values are latency minus one. The counter reaches zero
    // in the last BUSY cycle.
    localparam logic [CNT_W-1:0] ADD_CNT  = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] SQRT_CNT = CNT_W'(SQRT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fpu_start;
    logic [3:0]       r_fpu_op;
    logic             r_fpu_abort;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic             r_wb_int;

    logic             w_legal;
    logic [3:0]       w_op;
    logic [CNT_W-1:0] w_cnt_init;
    logic             w_wb_int;
    logic             w_accept;

    // Instruction classification
    always_comb begin
        w_legal    = 1'b1;
        w_op       = OP_ADD;
        w_cnt_init = '0;
        w_wb_int   = 1'b0;
        unique case (funct_7)
            7'b0000000: begin w_op = OP_ADD;  w_cnt_init = ADD_CNT;  end
            7'b0000100: begin w_op = OP_SUB;  w_cnt_init = ADD_CNT;  end
            7'b0001000: begin w_op = OP_MUL;  w_cnt_init = MUL_CNT;  end
            7'b0001100: begin w_op = OP_DIV;  w_cnt_init = DIV_CNT;  end
            7'b0101100: begin w_op = OP_SQRT; w_cnt_init = SQRT_CNT; end
            7'b0010000: begin
                w_op    = OP_SGNJ;
                w_legal = (funct_3 <= 3'd2);
            end
            7'b0010100: begin
                w_op    = OP_MINMAX;
                w_legal = (funct_3 <= 3'd1);
            end
            7'b1010000: begin
                w_op     = OP_CMP;
                w_wb_int = 1'b1;
                w_legal  = (funct_3 <= 3'd2);
            end
            7'b1100000: begin w_op = OP_CVT_W_S; w_wb_int = 1'b1; end
            7'b1101000: begin w_op = OP_CVT_S_W; end
            // funct_3 = 1 under this funct_7 is FCLASS, which this FPU lacks
            7'b1110000: begin
                w_op     = OP_MV_X_W;
                w_wb_int = 1'b1;
                w_legal  = (funct_3 == 3'd0);
            end
            7'b1111000: begin w_op = OP_MV_W_X; end
            default:    begin w_legal = 1'b0; end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) & issue_valid & w_legal & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_fpu_start <= 1'b0;
            r_fpu_op    <= 4'd0;
            r_fpu_abort <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_int    <= 1'b0;
        end else begin
            r_fpu_start <= 1'b0;
            r_fpu_abort <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_BUSY;
                        r_cnt       <= w_cnt_init;
                        r_fpu_op    <= w_op;
                        r_wb_rd     <= rd;
                        r_wb_int    <= w_wb_int;
                        r_fpu_start <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_fpu_abort <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state    <= S_WB;
                        r_wb_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    // A flush takes priority over a same-cycle handshake.
                    // The op still counts as aborted.
                    if (flush) begin
                        r_state     <= S_IDLE;
                        r_wb_valid  <= 1'b0;
                        r_fpu_abort <= 1'b1;
                    end else if (wb_ready) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

    // The stall drops in the handshake cycle. Decode therefore advances on
    // the same edge that returns the sequencer to IDLE, and the held
    // instruction is not issued a second time.
    assign stall     = w_accept | (r_state == S_BUSY) | ((r_state == S_WB) & ~wb_ready);
    assign illegal   = (r_state == S_IDLE) & issue_valid & ~w_legal;
    assign fpu_start = r_fpu_start;
    assign fpu_op    = r_fpu_op;
    assign fpu_abort = r_fpu_abort;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_int    = r_wb_int;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_sequencer
//
// Directed testbench for fpu_sequencer. Inputs are driven 1 time unit after
// the rising edge. Outputs are sampled 1 time unit later, well clear of the
// edge. Cycle C0 is the cycle in which the instruction is presented.
// ---------------------------------------------------------------------------
module tb_fpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [6:0] funct_7;
    logic [2:0] funct_3;
    logic [4:0] rd;
    logic       wb_ready;
    logic       flush;
    logic       stall;
    logic       illegal;
    logic       fpu_start;
    logic [3:0] fpu_op;
    logic       fpu_abort;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_int;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .funct_7     (funct_7),
        .funct_3     (funct_3),
        .rd          (rd),
        .wb_ready    (wb_ready),
        .flush       (flush),
        .stall       (stall),
        .illegal     (illegal),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_abort   (fpu_abort),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_int      (wb_int),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
        issue_valid = 1'b1;
        funct_7     = f7;
        funct_3     = f3;
        rd          = d;
    endtask

    // Runs one single-cycle operation (latency 1) with wb_ready held high
    task automatic run_single(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [4:0] d, input logic [3:0] op, input logic wi);
        cyc(); present(f7, f3, d); wb_ready = 1'b1; settle();
        chk({tag, "_c0_stall"}, stall, 1);
        chk({tag, "_c0_illegal"}, illegal, 0);
        cyc(); issue_valid = 1'b0; settle();
        chk({tag, "_c1_start"}, fpu_start, 1);
        chk({tag, "_c1_op"}, fpu_op, op);
        chk({tag, "_c1_wbv"}, wb_valid, 0);
        cyc(); settle();
        chk({tag, "_c2_wbv"}, wb_valid, 1);
        chk({tag, "_c2_wbint"}, wb_int, wi);
        chk({tag, "_c2_wbrd"}, wb_rd, d);
        chk({tag, "_c2_stall"}, stall, 0);
        cyc(); settle();
        chk({tag, "_c3_busy"}, busy, 0);
        chk({tag, "_c3_wbv"}, wb_valid, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        funct_7     = 7'd0;
        funct_3     = 3'd0;
        rd          = 5'd0;
        wb_ready    = 1'b0;
        flush       = 1'b0;
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_start", fpu_start, 0);
        chk("rst_op", fpu_op, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbrd", wb_rd, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // FADD rd=5, decode holds the instruction until the handshake cycle
        cyc(); present(7'b0000000, 3'd0, 5'd5); wb_ready = 1'b1; settle();
        chk("fadd_c0_stall", stall, 1);
        chk("fadd_c0_illegal", illegal, 0);
        chk("fadd_c0_start", fpu_start, 0);
        cyc(); settle();
        chk("fadd_c1_start", fpu_start, 1);
        chk("fadd_c1_op", fpu_op, 0);
        chk("fadd_c1_stall", stall, 1);
        chk("fadd_c1_busy", busy, 1);
        cyc(); settle();
        chk("fadd_c2_start", fpu_start, 0);
        chk("fadd_c2_stall", stall, 1);
        chk("fadd_c2_wbv", wb_valid, 0);
        cyc(); settle();
        chk("fadd_c3_wbv", wb_valid, 1);
        chk("fadd_c3_wbrd", wb_rd, 5);
        chk("fadd_c3_wbint", wb_int, 0);
        chk("fadd_c3_stall", stall, 0);
        cyc(); issue_valid = 1'b0; settle();
        chk("fadd_c4_busy", busy, 0);
        chk("fadd_c4_wbv", wb_valid, 0);
        chk("fadd_c4_start", fpu_start, 0);

        // FDIV rd=20, wb_ready held low three extra cycles
        cyc(); present(7'b0001100, 3'd0, 5'd20); wb_ready = 1'b0; settle();
        chk("fdiv_c0_stall", stall, 1);
        for (int c = 1; c <= 12; c++) begin
            cyc(); issue_valid = 1'b0; settle();
            chk($sformatf("fdiv_c%0d_busy", c), busy, 1);
            chk($sformatf("fdiv_c%0d_stall", c), stall, 1);
            chk($sformatf("fdiv_c%0d_wbv", c), wb_valid, 0);
            chk($sformatf("fdiv_c%0d_start", c), fpu_start, (c == 1));
        end
        for (int c = 13; c <= 16; c++) begin
            cyc(); wb_ready = (c == 16); settle();
            chk($sformatf("fdiv_c%0d_wbv", c), wb_valid, 1);
            chk($sformatf("fdiv_c%0d_wbrd", c), wb_rd, 20);
            chk($sformatf("fdiv_c%0d_stall", c), stall, (c != 16));
        end
        cyc(); wb_ready = 1'b0; settle();
        chk("fdiv_c17_busy", busy, 0);
        chk("fdiv_c17_wbv", wb_valid, 0);

        // FEQ: single-cycle, integer write-back
        run_single("feq", 7'b1010000, 3'd2, 5'd9, 4'd7, 1'b1);
        run_single("fsgnjn", 7'b0010000, 3'd1, 5'd10, 4'd5, 1'b0);
        run_single("fmax", 7'b0010100, 3'd1, 5'd11, 4'd6, 1'b0);
        run_single("fcvt_w_s", 7'b1100000, 3'd0, 5'd13, 4'd8, 1'b1);
        run_single("fcvt_s_w", 7'b1101000, 3'd0, 5'd14, 4'd9, 1'b0);
        run_single("fmv_x_w", 7'b1110000, 3'd0, 5'd15, 4'd10, 1'b1);
        run_single("fmv_w_x", 7'b1111000, 3'd0, 5'd16, 4'd11, 1'b0);

        // Illegal: FCLASS encoding is not supported
        cyc(); present(7'b1110000, 3'd1, 5'd2); settle();
        chk("ill_illegal", illegal, 1);
        chk("ill_stall", stall, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc(); settle();
            chk($sformatf("ill_c%0d_start", c), fpu_start, 0);
            chk($sformatf("ill_c%0d_busy", c), busy, 0);
        end
        cyc(); present(7'b0010100, 3'd2, 5'd2); settle();
        chk("ill_minmax_f3", illegal, 1);
        cyc(); issue_valid = 1'b0; settle();
        chk("ill_minmax_busy", busy, 0);

        // FSQRT flushed at C8
        cyc(); present(7'b0101100, 3'd0, 5'd1); wb_ready = 1'b1; settle();
        chk("fsqrt_c0_stall", stall, 1);
        for (int c = 1; c <= 8; c++) begin
            cyc(); issue_valid = 1'b0; flush = (c == 8); settle();
            chk($sformatf("fsqrt_c%0d_busy", c), busy, 1);
        end
        cyc(); flush = 1'b0; settle();
        chk("fsqrt_c9_abort", fpu_abort, 1);
        chk("fsqrt_c9_busy", busy, 0);
        chk("fsqrt_c9_wbv", wb_valid, 0);
        chk("fsqrt_c9_stall", stall, 0);
        cyc(); settle();
        chk("fsqrt_c10_abort", fpu_abort, 0);
        for (int c = 11; c <= 20; c++) begin
            cyc(); settle();
            chk($sformatf("fsqrt_c%0d_wbv", c), wb_valid, 0);
        end

        // FMUL after the flush issues cleanly
        cyc(); present(7'b0001000, 3'd0, 5'd3); settle();
        chk("fmul_c0_stall", stall, 1);
        cyc(); issue_valid = 1'b0; settle();
        chk("fmul_c1_start", fpu_start, 1);
        chk("fmul_c1_op", fpu_op, 2);
        cyc(); settle();
        chk("fmul_c2_wbv", wb_valid, 0);
        cyc(); settle();
        chk("fmul_c3_wbv", wb_valid, 0);
        chk("fmul_c3_stall", stall, 1);
        cyc(); settle();
        chk("fmul_c4_wbv", wb_valid, 1);
        chk("fmul_c4_wbrd", wb_rd, 3);
        cyc(); settle();
        chk("fmul_c5_busy", busy, 0);

        // Flush in WB beats a same-cycle wb_ready
        cyc(); present(7'b0000000, 3'd0, 5'd6); settle();
        cyc(); issue_valid = 1'b0; settle();
        cyc(); settle();
        cyc(); flush = 1'b1; settle();
        chk("fwb_c3_wbv", wb_valid, 1);
        chk("fwb_c3_stall", stall, 0);
        cyc(); flush = 1'b0; settle();
        chk("fwb_c4_abort", fpu_abort, 1);
        chk("fwb_c4_wbv", wb_valid, 0);
        chk("fwb_c4_busy", busy, 0);

        // Issue together with flush in IDLE is not accepted
        cyc(); present(7'b0000000, 3'd0, 5'd8); flush = 1'b1; settle();
        chk("iflush_stall", stall, 0);
        cyc(); issue_valid = 1'b0; flush = 1'b0; settle();
        chk("iflush_busy", busy, 0);
        chk("iflush_start", fpu_start, 0);

        // FMUL interrupted by asynchronous reset at C5 (in WB, wb_ready low)
        cyc(); present(7'b0001000, 3'd0, 5'd7); wb_ready = 1'b0; settle();
        cyc(); issue_valid = 1'b0; settle();
        cyc(); cyc(); cyc(); settle();
        chk("rmul_c4_wbv", wb_valid, 1);
        chk("rmul_c4_wbrd", wb_rd, 7);
        cyc(); rst_n = 1'b0; settle();
        chk("rmul_rst_wbv", wb_valid, 0);
        chk("rmul_rst_wbrd", wb_rd, 0);
        chk("rmul_rst_op", fpu_op, 0);
        chk("rmul_rst_busy", busy, 0);
        chk("rmul_rst_stall", stall, 0);
        chk("rmul_rst_wbint", wb_int, 0);
        cyc(); rst_n = 1'b1;

        // FSUB after reset
        cyc(); present(7'b0000100, 3'd0, 5'd12); wb_ready = 1'b1; settle();
        cyc(); issue_valid = 1'b0; settle();
        chk("fsub_c1_op", fpu_op, 1);
        chk("fsub_c1_start", fpu_start, 1);
        cyc(); settle();
        chk("fsub_c2_wbv", wb_valid, 0);
        cyc(); settle();
        chk("fsub_c3_wbv", wb_valid, 1);
        chk("fsub_c3_wbrd", wb_rd, 12);
        cyc(); settle();
        chk("fsub_c4_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
